// File: rtl/uart_rx_framer.sv
// uart_rx_framer: sync hunt, length-prefixed capture, additive checksum verify, verified-frame drain
module uart_rx_framer #(
  parameter logic [7:0] SyncByte      = 8'hA5,
  parameter int         MaxLen        = 16,
  parameter int         TimeoutCycles = 2000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_byte,
  output logic       o_valid,
  input  logic       i_ready,
  output logic [7:0] o_data,
  output logic       o_last,
  output logic [7:0] o_frame_len,
  output logic       o_busy,
  output logic       o_err_len,
  output logic       o_err_chk,
  output logic       o_err_timeout,
  output logic       o_err_drop
);
  localparam int IW = (MaxLen > 1) ? $clog2(MaxLen) : 1;
  localparam int TW = $clog2(TimeoutCycles + 1);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHK, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic [7:0]      len_q, sum_q;
  logic [IW-1:0]   wr_idx_q, rd_idx_q;
  logic [TW-1:0]   cnt_q;
  logic [7:0]      mem [MaxLen];
  logic            err_len_d, err_chk_d, err_to_d, err_drop_d;
  logic            timed, expire, len_bad, wr_last, rd_last, fire;

  assign timed   = state_q == S_LEN || state_q == S_PAYLOAD || state_q == S_CHK;
  assign expire  = !i_rx_valid && cnt_q == TW'(TimeoutCycles - 1);
  assign len_bad = i_rx_byte == 8'd0 || i_rx_byte > 8'(MaxLen);
  assign wr_last = 8'(wr_idx_q) == len_q - 8'd1;
  assign rd_last = 8'(rd_idx_q) == len_q - 8'd1;
  assign fire    = o_valid && i_ready;
  assign o_valid = state_q == S_DRAIN;
  assign o_data  = o_valid ? mem[rd_idx_q] : 8'h00;
  assign o_last  = o_valid && rd_last;
  assign o_busy  = state_q != S_IDLE;

  // next-state and error decode; a byte arriving on the expiry cycle suppresses the timeout
  always_comb begin
    state_d    = state_q;
    err_len_d  = 1'b0;
    err_chk_d  = 1'b0;
    err_to_d   = 1'b0;
    err_drop_d = 1'b0;
    case (state_q)
      S_IDLE:    state_d = (i_rx_valid && i_rx_byte == SyncByte) ? S_LEN : S_IDLE;
      S_LEN:     if (i_rx_valid) begin
                   err_len_d = len_bad;
                   state_d   = len_bad ? S_IDLE : S_PAYLOAD;
                 end
      S_PAYLOAD: state_d = (i_rx_valid && wr_last) ? S_CHK : S_PAYLOAD;
      S_CHK:     if (i_rx_valid) begin
                   err_chk_d = i_rx_byte != sum_q;
                   state_d   = (i_rx_byte == sum_q) ? S_DRAIN : S_IDLE;
                 end
      S_DRAIN:   begin
                   err_drop_d = i_rx_valid;
                   state_d    = (fire && rd_last) ? S_IDLE : S_DRAIN;
                 end
      default:   state_d = S_IDLE;
    endcase
    if (timed && expire) begin
      err_to_d = 1'b1;
      state_d  = S_IDLE;
    end
  end

  // state, datapath registers and registered error pulses
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= S_IDLE;
      len_q         <= '0;
      sum_q         <= '0;
      wr_idx_q      <= '0;
      rd_idx_q      <= '0;
      cnt_q         <= '0;
      o_frame_len   <= '0;
      o_err_len     <= 1'b0;
      o_err_chk     <= 1'b0;
      o_err_timeout <= 1'b0;
      o_err_drop    <= 1'b0;
    end else begin
      state_q       <= state_d;
      o_err_len     <= err_len_d;
      o_err_chk     <= err_chk_d;
      o_err_timeout <= err_to_d;
      o_err_drop    <= err_drop_d;
      if (state_q == S_IDLE && state_d == S_LEN) cnt_q <= '0;
      else if (timed) cnt_q <= i_rx_valid ? '0 : cnt_q + TW'(1);
      if (state_q == S_LEN && i_rx_valid && !len_bad) begin
        len_q    <= i_rx_byte;
        sum_q    <= i_rx_byte;
        wr_idx_q <= '0;
      end
      if (state_q == S_PAYLOAD && i_rx_valid) begin
        sum_q    <= sum_q + i_rx_byte;
        wr_idx_q <= wr_idx_q + IW'(1);
      end
      if (state_q == S_CHK && i_rx_valid && i_rx_byte == sum_q) begin
        o_frame_len <= len_q;
        rd_idx_q    <= '0;
      end
      if (fire) rd_idx_q <= rd_idx_q + IW'(1);
    end
  end

  // payload buffer; never read outside DRAIN so it needs no reset
  always_ff @(posedge i_clk) begin
    if (state_q == S_PAYLOAD && i_rx_valid) mem[wr_idx_q] <= i_rx_byte;
  end
endmodule

// File: tb/tb_uart_rx_framer.sv
// tb_uart_rx_framer: directed frames with scoreboard-checked beats and error pulses
module tb_uart_rx_framer;
  localparam int T = 2000;
  logic clk = 1'b0, rst_n = 1'b0, rx_valid = 1'b0, ready = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic o_valid, o_last, o_busy, e_len, e_chk, e_to, e_drop;
  logic [7:0] o_data, o_frame_len;
  int n_chk = 0, n_pass = 0;
  logic [16:0] exp_beat[$];
  logic [3:0]  exp_err[$];
  logic [7:0]  pl[256];
  logic [7:0]  c;

  uart_rx_framer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_valid(rx_valid), .i_rx_byte(rx_byte),
    .o_valid(o_valid), .i_ready(ready), .o_data(o_data), .o_last(o_last),
    .o_frame_len(o_frame_len), .o_busy(o_busy), .o_err_len(e_len), .o_err_chk(e_chk),
    .o_err_timeout(e_to), .o_err_drop(e_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic push_beats(input int n);
    for (int i = 0; i < n; i++) exp_beat.push_back({8'(n), i == n - 1, pl[i]});
  endtask

  task automatic frame(input int n, input logic [7:0] chk, input bit good);
    send(8'hA5);
    send(8'(n));
    for (int i = 0; i < n; i++) send(pl[i]);
    if (good) push_beats(n);
    else exp_err.push_back(4'b0010);
    send(chk);
  endtask

  task automatic settle(input string name);
    int k;
    k = 0;
    while (exp_beat.size() + exp_err.size() != 0 && k < 300) begin
      tick(1);
      k++;
    end
    tick(2);
    check(name, exp_beat.size() + exp_err.size(), 0);
  endtask

  task automatic check_reset(input string name);
    check({name, "_out"}, {o_valid, o_last, o_busy, e_len, e_chk, e_to, e_drop}, 0);
    check({name, "_data"}, o_data, 8'h00);
    check({name, "_flen"}, o_frame_len, 8'h00);
  endtask

  // scoreboard monitor: every beat, stalled beat and error pulse is matched against the queues
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_valid && ready) begin
        if (exp_beat.size() == 0) check("beat_unexpected", {o_last, o_data}, 0);
        else check("beat", {o_frame_len, o_last, o_data}, exp_beat.pop_front());
      end else if (o_valid && exp_beat.size() != 0) begin
        check("stall_hold", {o_frame_len, o_last, o_data}, exp_beat[0]);
      end
      if ({e_drop, e_to, e_chk, e_len} != 4'b0000) begin
        if (exp_err.size() == 0) check("err_unexpected", {e_drop, e_to, e_chk, e_len}, 0);
        else check("err", {e_drop, e_to, e_chk, e_len}, exp_err.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_reset("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1);
    send(8'h00); send(8'hFF); send(8'h5A);
    tick(2);
    check("junk_busy", o_busy, 0);
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    frame(3, 8'h69, 1);
    check("lat_valid", {o_valid, o_last, o_data}, {1'b1, 1'b0, 8'h11});
    check("lat_len", o_frame_len, 8'd3);
    tick(2);
    check("last_beat", {o_valid, o_last, o_data}, {1'b1, 1'b1, 8'h33});
    tick(1);
    check("drain_done", {o_valid, o_busy}, 0);
    settle("good");
    frame(3, 8'h6A, 0);
    check("chk_pulse", {e_chk, o_valid}, 2'b10);
    tick(1);
    check("chk_once", e_chk, 0);
    frame(3, 8'h69, 1);
    settle("after_bad");
    send(8'hA5);
    exp_err.push_back(4'b0001);
    send(8'h00);
    check("len0_pulse", e_len, 1);
    tick(1);
    check("len0_once", e_len, 0);
    send(8'hA5);
    exp_err.push_back(4'b0001);
    send(8'h11);
    check("len17_pulse", {e_len, o_busy}, 2'b10);
    settle("len_bounds");
    c = 8'd16;
    for (int i = 0; i < 16; i++) begin
      pl[i] = 8'(i + 1);
      c = c + pl[i];
    end
    frame(16, c, 1);
    settle("len16");
    ready = 1'b0;
    pl[0] = 8'h3C; pl[1] = 8'h4D; pl[2] = 8'h5E;
    frame(3, 8'hEA, 1);
    for (int b = 0; b < 3; b++) begin
      tick(5);
      if (b == 1) begin
        exp_err.push_back(4'b1000);
        send(8'hA5);
      end
      ready = 1'b1;
      tick(1);
      ready = 1'b0;
    end
    ready = 1'b1;
    tick(2);
    check("drop_nostart", {o_valid, o_busy}, 0);
    settle("backpressure");
    send(8'hA5); send(8'h03); send(8'h11);
    tick(T - 1);
    check("to_early", {e_to, o_busy}, 2'b01);
    exp_err.push_back(4'b0100);
    tick(1);
    check("to_pulse", {e_to, o_busy}, 2'b10);
    settle("timeout");
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    send(8'hA5); send(8'h03); send(8'h11);
    tick(T - 1);
    send(8'h22);
    check("expiry_byte", {e_to, o_busy}, 2'b01);
    send(8'h33);
    push_beats(3);
    send(8'h69);
    settle("expiry_frame");
    send(8'hA5); send(8'h03); send(8'h11);
    rst_n = 1'b0;
    #1;
    check_reset("mid_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1);
    pl[0] = 8'h5A; pl[1] = 8'hC3;
    frame(2, 8'h1F, 1);
    settle("post_rst");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_rx_framer.md
# uart_rx_framer

Packet framer and buffer controller that sits directly behind the UART receiver, consuming its one-cycle byte strobes. It hunts for a sync byte, captures a length-prefixed payload into an internal buffer, and verifies an 8-bit additive checksum. Only fully verified frames are released downstream, over a valid/ready byte stream with a last marker. Malformed, corrupted or stalled frames are discarded and reported as one-cycle error pulses.

## Interface
- SyncByte, 8'hA5, frame start marker
- MaxLen, 16, maximum payload bytes (1..255); buffer depth
- TimeoutCycles, 2000, idle clocks allowed between bytes inside a frame before abort
- i_clk  in  1  clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_rx_valid  in  1  one-cycle strobe, receiver byte available
- i_rx_byte  in  8  receiver byte, qualified by i_rx_valid
- o_valid  out  1  payload byte available downstream
- i_ready  in  1  downstream accepts byte when high with o_valid
- o_data  out  8  payload byte
- o_last  out  1  marks final byte of the frame, qualified by o_valid
- o_frame_len  out  8  length of the frame being drained; holds the last value otherwise
- o_busy  out  1  high in any state except IDLE
- o_err_len  out  1  pulse: LEN byte was 0 or greater than MaxLen
- o_err_chk  out  1  pulse: checksum mismatch
- o_err_timeout  out  1  pulse: inter-byte timeout inside a frame
- o_err_drop  out  1  pulse: byte arrived during DRAIN and was discarded

## Operation
- Frame format on the wire: SYNC, LEN, LEN payload bytes, CHK.
  - CHK = (LEN + sum of payload) mod 256.
- FSM states: IDLE, LEN, PAYLOAD, CHK, DRAIN.
- IDLE
  - i_rx_valid with byte == SyncByte: go to LEN.
  - Any other byte: ignored, no error.
- LEN
  - Byte == 0 or byte > MaxLen: pulse o_err_len, go to IDLE.
  - Otherwise: len <= byte, sum <= byte, wr_idx <= 0, go to PAYLOAD.
- PAYLOAD
  - Each byte: buf[wr_idx] <= byte, sum <= sum + byte (8-bit wrap), wr_idx++.
  - The byte written at wr_idx == len-1 moves the FSM to CHK.
- CHK
  - Byte == sum: o_frame_len <= len, rd_idx <= 0, go to DRAIN.
  - Otherwise: pulse o_err_chk, go to IDLE. The buffer contents are never exposed.
- DRAIN
  - o_valid = 1, o_data = buf[rd_idx], o_last = (rd_idx == len-1).
  - o_valid && i_ready: rd_idx++. On the last beat, go to IDLE.
  - Any i_rx_valid in DRAIN: pulse o_err_drop and discard the byte. A SyncByte here does not start a frame.
- Timeout (LEN, PAYLOAD, CHK only)
  - Counter clears on entry to LEN and on every i_rx_valid; otherwise increments.
  - Reaching TimeoutCycles: pulse o_err_timeout, go to IDLE.
  - i_rx_valid in the same cycle as expiry: the byte wins, the counter clears, no timeout.
  - The counter is frozen in IDLE and DRAIN.
- Widths
  - wr_idx/rd_idx: $clog2(MaxLen) bits, minimum 1.
  - Timeout counter: $clog2(TimeoutCycles+1) bits.
  - sum: 8 bits.
- Reset mid-operation: FSM returns to IDLE, the partial frame is lost, and all outputs take their reset values.

## Timing
- Reset values: o_valid 0, o_last 0, o_data 8'h00, o_frame_len 0, o_busy 0, all o_err_* 0.
- All outputs are registered or decoded from registered state only. There is no combinational path from i_rx_valid/i_rx_byte to any output.
- CHK byte accepted at edge N: o_valid high from cycle N+1. First byte on o_data, o_last correct in the same cycle.
- Throughput: one byte per cycle while i_ready = 1. A LEN-byte frame drains in LEN cycles at full rate.
- o_data/o_last hold stable while o_valid && !i_ready.
- After the last handshake, o_valid drops the next cycle and a new SYNC is accepted that same cycle (IDLE).
- Error pulses are exactly one cycle, asserted the cycle after the offending byte or timeout expiry. At most one error is flagged per cycle.
- o_busy rises the cycle after SYNC is accepted and falls the cycle after return to IDLE.

## Test plan
- Good frame: A5 03 11 22 33 69, i_ready = 1 -> o_data 11, 22, 33 on consecutive cycles; o_last with 33; o_frame_len = 3; no error pulses.
- Bad checksum: A5 03 11 22 33 6A -> one o_err_chk pulse, o_valid never asserts; a following good frame is delivered intact.
- Length bounds
  - A5 00 -> o_err_len.
  - A5 11 (17, MaxLen = 16) -> o_err_len.
  - A5 10 + 16 bytes + correct CHK -> 16 beats, o_last on the 16th.
- Backpressure and drop: good 3-byte frame with i_ready low for 5 cycles on each beat -> o_data/o_last stable while stalled. Inject byte A5 during DRAIN -> o_err_drop pulse, no new frame started.
- Timeout: A5 03 11, then silence.
  - Silence of TimeoutCycles -> o_err_timeout, o_busy falls.
  - A byte on the exact expiry cycle -> no timeout, frame continues.
- Reset and noise
  - Assert i_rst_n low mid-PAYLOAD -> all outputs at reset values; next good frame delivered.
  - Junk bytes 00 FF 5A before SYNC -> ignored, no errors.
